// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous block-RAM FIFO: credit-based dequeue,
// fixed-latency return capture, and a small buffer re-presented as valid/ready.
module fifo_stream_reader #(
    parameter int WIDTH    = 12,
    parameter int LATENCY  = 2,
    parameter int BUFDEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fifo_empty,
    output logic                      fifo_dequeue,
    input  logic [WIDTH-1:0]          fifo_data,
    input  logic                      fifo_data_valid,
    output logic [WIDTH-1:0]          m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(BUFDEPTH):0] level,
    output logic                      protocol_error
);
    localparam int PW = $clog2(BUFDEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(BUFDEPTH);

    if (LATENCY < 1 || BUFDEPTH < 2 || (BUFDEPTH & (BUFDEPTH - 1)) != 0) begin : g_param_check
        $error("fifo_stream_reader: LATENCY must be >= 1 and BUFDEPTH a power of 2 >= 2");
    end

    logic [WIDTH-1:0] r_buf [BUFDEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [LW-1:0]    r_in_flight;
    logic             r_protocol_error;

    logic [LW:0]      w_used;
    logic             w_has_credit;
    logic             w_ret;
    logic             w_pop;
    logic             w_overflow;
    logic             w_stray;
    logic             w_accept;

    // Credit is derived from registered state only, so the only combinational
    // input into fifo_dequeue is fifo_empty.
    assign w_used       = {1'b0, r_count} + {1'b0, r_in_flight};
    assign w_has_credit = w_used < (LW+1)'(BUFDEPTH);
    assign fifo_dequeue = !reset && !fifo_empty && w_has_credit;

    assign w_ret      = fifo_data_valid && (r_in_flight != '0);
    assign w_stray    = fifo_data_valid && (r_in_flight == '0);
    assign w_pop      = m_valid && m_ready;
    assign w_overflow = w_ret && (r_count == FULL) && !w_pop;
    assign w_accept   = w_ret && !w_overflow;

    assign m_valid        = (r_count != '0);
    assign m_data         = r_buf[r_rd_ptr];
    assign level          = r_count;
    assign protocol_error = r_protocol_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the buffer is cleared on reset so m_data reads 0 afterwards,
            // which costs a reset net on every storage bit.
            for (int i = 0; i < BUFDEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            // NOTE: non-blocking so the read of m_data this cycle sees the old entry.
            r_buf[r_wr_ptr] <= fifo_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_in_flight      <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase

            // A dropped overflow beat still retires its in-flight slot.
            case ({fifo_dequeue, w_ret})
                2'b10:   r_in_flight <= r_in_flight + LW'(1);
                2'b01:   r_in_flight <= r_in_flight - LW'(1);
                default: r_in_flight <= r_in_flight;
            endcase

            if (w_stray || w_overflow) begin
                r_protocol_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random bench for fifo_stream_reader with a fixed-latency FIFO
// model and an in-order scoreboard of every enqueued word.
module tb_fifo_stream_reader;
    localparam int W     = 12;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         clock;
    logic         reset;
    logic         fifo_empty;
    logic         fifo_dequeue;
    logic [W-1:0] fifo_data;
    logic         fifo_data_valid;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [2:0]   level;
    logic         protocol_error;

    fifo_stream_reader #(.WIDTH(W), .LATENCY(LAT), .BUFDEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_dequeue    (fifo_dequeue),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .level           (level),
        .protocol_error  (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           tests;
    int           failed;
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] sb [$];
    logic         pipe_v [LAT];
    logic [W-1:0] pipe_d [LAT];
    logic         last_deq;
    logic         last_mv;
    int           deq_count;
    bit           check_inv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pipe_count();
        int n = 0;
        for (int i = 0; i < LAT; i++) n += int'(pipe_v[i]);
        return n;
    endfunction

    task automatic drive_fifo();
        fifo_empty      = (fifo_q.size() == 0);
        fifo_data_valid = pipe_v[LAT-1];
        fifo_data       = pipe_d[LAT-1];
    endtask

    task automatic clear_model();
        fifo_q.delete();
        sb.delete();
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        drive_fifo();
    endtask

    // One clock: sample at the falling edge, then advance the FIFO model just
    // after the rising edge and optionally enqueue a word.
    task automatic cycle(input bit enq, input logic [W-1:0] word);
        bit           deq;
        bit           pop;
        logic [W-1:0] exp;
        @(negedge clock);
        deq      = fifo_dequeue;
        pop      = m_valid && m_ready;
        last_deq = deq;
        last_mv  = m_valid;
        if (deq) deq_count++;
        if (check_inv) begin
            check("inv_inflight", pipe_count() <= LAT + 1, 1);
            check("inv_total", (int'(level) + pipe_count()) <= DEPTH, 1);
        end
        if (pop) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("data", m_data, exp);
            end
        end
        @(posedge clock);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = 1'b0;
        pipe_d[0] = '0;
        if (deq) begin
            check("deq_real", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                pipe_v[0] = 1'b1;
                pipe_d[0] = fifo_q.pop_front();
            end
        end
        if (enq) begin
            fifo_q.push_back(word);
            sb.push_back(word);
        end
        drive_fifo();
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || m_valid); i++) cycle(0, '0);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int max_run;
        tests     = 0;
        failed    = 0;
        deq_count = 0;
        check_inv = 1'b0;
        reset     = 1'b1;
        m_ready   = 1'b1;
        clear_model();

        // Reset values.
        cycle(0, '0);
        cycle(0, '0);
        check("rst_deq", fifo_dequeue, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_level", level, 0);
        check("rst_err", protocol_error, 0);

        // Five preloaded words: three-cycle latency, back-to-back output.
        for (int i = 1; i <= 5; i++) begin
            fifo_q.push_back(W'(i));
            sb.push_back(W'(i));
        end
        drive_fifo();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle(0, '0);
            check($sformatf("t1_deq_c%0d", c), last_deq, (c < 5));
            check($sformatf("t1_mvalid_c%0d", c), last_mv, (c >= 3 && c < 8));
        end
        check("t1_level", level, 0);
        check("t1_sb", sb.size(), 0);

        // Backpressure: ten words, only BUFDEPTH dequeues, head held.
        m_ready   = 1'b0;
        deq_count = 0;
        for (int i = 0; i < 10; i++) cycle(1, W'(12'h100 + i));
        for (int i = 0; i < 10; i++) cycle(0, '0);
        check("t2_deq_count", deq_count, DEPTH);
        check("t2_level", level, DEPTH);
        check("t2_mvalid", m_valid, 1);
        check("t2_head", m_data, 12'h100);
        for (int i = 0; i < 3; i++) cycle(0, '0);
        check("t2_head_stable", m_data, 12'h100);
        drain("t2_drain");
        check("t2_level_end", level, 0);

        // Streaming at one word per cycle.
        m_ready = 1'b1;
        run     = 0;
        max_run = 0;
        for (int i = 0; i < 130; i++) begin
            cycle(i < 100, W'(12'h200 + i));
            run = last_mv ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check("t3_run", max_run, 100);
        check("t3_sb", sb.size(), 0);
        check("t3_err", protocol_error, 0);

        // Random enqueue and backpressure.
        check_inv = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), W'($urandom));
        end
        drain("t4_drain");
        check("t4_err", protocol_error, 0);
        check("t4_level", level, 0);

        // Stray strobe with nothing in flight.
        m_ready = 1'b0;
        cycle(1, 12'h3a1);
        cycle(1, 12'h3a2);
        for (int i = 0; i < 10 && !(level == 3'd2 && pipe_count() == 0); i++) cycle(0, '0);
        check("t5_level_before", level, 2);
        fifo_data_valid = 1'b1;
        fifo_data       = 12'heee;
        cycle(0, '0);
        check("t5_err_set", protocol_error, 1);
        check("t5_level_kept", level, 2);
        cycle(0, '0);
        check("t5_err_sticky", protocol_error, 1);
        check("t5_head_kept", m_data, 12'h3a1);
        reset = 1'b1;
        clear_model();
        cycle(0, '0);
        check("t5_err_cleared", protocol_error, 0);
        reset = 1'b0;

        // Reset with words both buffered and in flight.
        for (int i = 0; i < 6; i++) begin
            fifo_q.push_back(W'(12'h400 + i));
            sb.push_back(W'(12'h400 + i));
        end
        drive_fifo();
        for (int i = 0; i < 10 && !(level == 3'd2 && pipe_count() == 2); i++) cycle(0, '0);
        check("t6_level_pre", level, 2);
        check("t6_inflight_pre", pipe_count(), 2);
        reset = 1'b1;
        clear_model();
        cycle(0, '0);
        check("t6_mvalid", m_valid, 0);
        check("t6_level", level, 0);
        check("t6_deq", fifo_dequeue, 0);
        reset   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, '0);
        check("t6_err", protocol_error, 0);
        check("t6_mvalid_after", m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
